multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Parametrised multi-cycle control sequencer for the MIPS datapath: takes one decoded instruction at a time,
//  steps FETCH/DECODE/EXEC/MEM/FP/WB states and drives per-state datapath strobes.
//  Adds memory wait/timeout, multi-cycle FP latency, BNE polarity, CP1 decode on fmt field, illegal-op flag.
// PARAMETERS
//  FP_LATENCY   4   cycles fp_operation held in S_FP (>=1)
//  MEM_TIMEOUT  16  max cycles in S_MEM awaiting mem_ready before abort (>=2)
// PORTS
//  clk            in   1  system clock; all state on rising edge
//  rst            in   1  synchronous, active-high reset
//  instr_valid    in   1  opcode/funct/fmt valid; accepted when instr_ready=1
//  instr_ready    out  1  FSM in S_IDLE and rst=0
//  opcode         in   6  instr[31:26]
//  fmt            in   5  instr[25:21], CP1 sub-decode
//  funct          in   6  instr[5:0]
//  mem_ready      in   1  memory completed current read/write this cycle
//  ir_write       out  1  pulse: latch instruction (accept cycle)
//  pc_write       out  1  pulse: PC update (jump in S_EXEC; all other instrs at retire)
//  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  out 1 each  datapath strobes
//  branch_ne      out  1  with branch: 1=BNE, 0=BEQ
//  jump           out  1  J in S_EXEC
//  alu_op         out  2  00 add, 01 sub, 10 funct, 11 logical-imm
//  imm_op         out  2  valid when alu_op=11: 00 AND, 01 OR, 10 XOR, 11 LUI
//  fp_reg_write, fp_reg_read, fp_operation, move_fp_to_cpu, move_cpu_to_fp  out 1 each  FP strobes
//  illegal_op     out  1  pulse in S_DECODE for unsupported opcode
//  mem_error      out  1  pulse when MEM_TIMEOUT expires
// BEHAVIOUR
//  - rst: state<=S_IDLE, counters<=0, latched opcode/fmt/funct<=0; all outputs 0 during rst.
//  - S_IDLE: instr_ready=1; instr_valid -> ir_write=1, latch fields, ->S_DECODE. Inputs ignored elsewhere.
//  - S_DECODE (1 cyc): R,LW,SW,LWC1,SWC1,BEQ,BNE,J,ADDI,ANDI,ORI,XORI,LUI ->S_EXEC;
//    CP1 fmt=00000 (MFC1)/00100 (MTC1) ->S_WB; other CP1 ->S_FP; else illegal_op=1, pc_write=1, ->S_IDLE.
//  - S_EXEC (1 cyc): alu_src=1 for imm/mem; alu_op: R=10, BEQ/BNE=01 (+branch, branch_ne for BNE),
//    ANDI/ORI/XORI/LUI=11 with imm_op, else 00. J: jump=1, pc_write=1. Next: mem ->S_MEM; BEQ/BNE ->
//    retire (pc_write=1) ->S_IDLE; J ->S_IDLE; else ->S_WB.
//  - S_MEM: mem_read (LW/LWC1) or mem_write (SW/SWC1, fp_reg_read=1 for SWC1) held every cycle until
//    mem_ready. On mem_ready: loads ->S_WB; stores retire ->S_IDLE. wait counter counts cycles in state;
//    if mem_ready=0 on cycle MEM_TIMEOUT: mem_error=1, pc_write=0, ->S_IDLE. mem_ready on that same
//    cycle wins (normal completion).
//  - S_FP: fp_operation=1, fp_reg_read=1 for exactly FP_LATENCY cycles, then ->S_WB.
//  - S_WB (1 cyc): R: reg_dst=1,reg_write=1; imm: reg_write=1; LW: mem_to_reg=1,reg_write=1;
//    LWC1: fp_reg_write=1 (mem_to_reg=0); MFC1: reg_write=1,move_fp_to_cpu=1;
//    MTC1: fp_reg_write=1,move_cpu_to_fp=1; FP op: fp_reg_write=1. pc_write=1; ->S_IDLE.
//  - Latency accept->next instr_ready: ALU 4, load 5+waits, store 4+waits, branch 3, J 3, MFC1/MTC1 3,
//    FP op 3+FP_LATENCY, illegal 2.
//  - Write strobes (reg_write, fp_reg_write, mem_write) never asserted outside stated states; at most one
//    of reg_write/fp_reg_write per cycle. Counters width $clog2(max+1); never wrap (cleared on state entry).
//  - rst mid-instruction: aborts immediately, no strobe in following cycle.
// TESTING
//  - ADD (op 000000,funct 100000) accepted c0 -> c2 alu_op=10; c3 reg_dst=1,reg_write=1,pc_write=1; c4 instr_ready=1.
//  - LW with mem_ready at 3rd S_MEM cycle -> mem_read high 3 cycles, then WB mem_to_reg=1,reg_write=1.
//  - SW, mem_ready held 0 (MEM_TIMEOUT=16) -> mem_write 16 cycles, mem_error pulse on 16th, no pc_write, S_IDLE.
//  - CP1 fmt=10000 (FP_LATENCY=4) -> fp_operation exactly 4 cycles, then fp_reg_write 1 cycle; MTC1 fmt=00100 ->
//    move_cpu_to_fp+fp_reg_write in WB.
//  - BNE (000101) -> EXEC: branch=1,branch_ne=1,alu_op=01,pc_write=1; opcode 111111 -> illegal_op pulse, ready after 2.
//  - rst asserted mid S_FP -> next cycle all outputs 0; after release instr_ready=1, new ORI gives imm_op=01.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the MIPS datapath. One decoded instruction is in flight at a time.
// The FSM steps through IDLE, DECODE, EXEC, MEM, FP and WB and drives the datapath strobes for each state.
module multicycle_control_fsm #(
  parameter int FP_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [5:0]  opcode,
  input  logic [4:0]  fmt,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        branch_ne,
  output logic        jump,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_op,
  output logic        fp_reg_write,
  output logic        fp_reg_read,
  output logic        fp_operation,
  output logic        move_fp_to_cpu,
  output logic        move_cpu_to_fp,
  output logic        illegal_op,
  output logic        mem_error,
  output logic [19:0] dbg_o
);

  // Handshake: an instruction is accepted on a rising edge when instr_valid and instr_ready are both 1.
  // instr_ready is 1 only in S_IDLE outside reset. Instruction fields are sampled only on that edge.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_FP     = 3'd4,
    S_WB     = 3'd5
  } state_e;

  localparam int CNT_MAX = (MEM_TIMEOUT > FP_LATENCY) ? MEM_TIMEOUT : FP_LATENCY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MEM_LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] FP_LAST  = CW'(FP_LATENCY - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_CP1  = 6'b010001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_LWC1 = 6'b110001;
  localparam logic [5:0] OP_SWC1 = 6'b111001;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q;
  logic [4:0]    fmt_q;
  logic [5:0]    funct_q;
  logic          accept;

  logic is_r, is_lw, is_sw, is_lwc1, is_swc1, is_beq, is_bne, is_j;
  logic is_addi, is_andi, is_ori, is_xori, is_lui, is_cp1;
  logic is_mfc1, is_mtc1, is_fpop, is_load, is_store, is_mem, is_imm, is_logic, is_branch;
  logic supported;
  logic [1:0] imm_sel;

  assign is_r      = (op_q == OP_R);
  assign is_lw     = (op_q == OP_LW);
  assign is_sw     = (op_q == OP_SW);
  assign is_lwc1   = (op_q == OP_LWC1);
  assign is_swc1   = (op_q == OP_SWC1);
  assign is_beq    = (op_q == OP_BEQ);
  assign is_bne    = (op_q == OP_BNE);
  assign is_j      = (op_q == OP_J);
  assign is_addi   = (op_q == OP_ADDI);
  assign is_andi   = (op_q == OP_ANDI);
  assign is_ori    = (op_q == OP_ORI);
  assign is_xori   = (op_q == OP_XORI);
  assign is_lui    = (op_q == OP_LUI);
  assign is_cp1    = (op_q == OP_CP1);
  assign is_mfc1   = is_cp1 && (fmt_q == 5'b00000);
  assign is_mtc1   = is_cp1 && (fmt_q == 5'b00100);
  assign is_fpop   = is_cp1 && !is_mfc1 && !is_mtc1;
  assign is_load   = is_lw || is_lwc1;
  assign is_store  = is_sw || is_swc1;
  assign is_mem    = is_load || is_store;
  assign is_logic  = is_andi || is_ori || is_xori || is_lui;
  assign is_imm    = is_addi || is_logic;
  assign is_branch = is_beq || is_bne;
  assign supported = is_r || is_mem || is_branch || is_j || is_imm;

  always_comb begin
    imm_sel = 2'b00;
    if (is_ori)  imm_sel = 2'b01;
    if (is_xori) imm_sel = 2'b10;
    if (is_lui)  imm_sel = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      fmt_q   <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q    <= opcode;
        fmt_q   <= fmt;
        funct_q <= funct;
      end
    end
  end

  // The counter restarts on every state change, so it only ever counts dwell time in S_MEM or S_FP.
  always_comb begin
    cnt_d = '0;
    if (!rst && (state_d == state_q) && (state_q == S_MEM || state_q == S_FP))
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    instr_ready    = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    reg_dst        = 1'b0;
    alu_src        = 1'b0;
    mem_to_reg     = 1'b0;
    reg_write      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    branch         = 1'b0;
    branch_ne      = 1'b0;
    jump           = 1'b0;
    alu_op         = 2'b00;
    imm_op         = 2'b00;
    fp_reg_write   = 1'b0;
    fp_reg_read    = 1'b0;
    fp_operation   = 1'b0;
    move_fp_to_cpu = 1'b0;
    move_cpu_to_fp = 1'b0;
    illegal_op     = 1'b0;
    mem_error      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            accept   = 1'b1;
            ir_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          if (supported)                state_d = S_EXEC;
          else if (is_mfc1 || is_mtc1)  state_d = S_WB;
          else if (is_fpop)             state_d = S_FP;
          else begin
            illegal_op = 1'b1;
            pc_write   = 1'b1;
            state_d    = S_IDLE;
          end
        end
        S_EXEC: begin
          alu_src = is_imm || is_mem;
          if (is_r)          alu_op = 2'b10;
          else if (is_branch) alu_op = 2'b01;
          else if (is_logic)  alu_op = 2'b11;
          if (is_logic) imm_op = imm_sel;
          branch    = is_branch;
          branch_ne = is_bne;
          jump      = is_j;
          if (is_j || is_branch) begin
            pc_write = 1'b1;
            state_d  = S_IDLE;
          end else if (is_mem) state_d = S_MEM;
          else                 state_d = S_WB;
        end
        S_MEM: begin
          mem_read    = is_load;
          mem_write   = is_store;
          fp_reg_read = is_swc1;
          // A completion on the final allowed cycle still counts as success.
          if (mem_ready) begin
            if (is_load) state_d = S_WB;
            else begin
              pc_write = 1'b1;
              state_d  = S_IDLE;
            end
          end else if (cnt_q == MEM_LAST) begin
            mem_error = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_FP: begin
          fp_operation = 1'b1;
          fp_reg_read  = 1'b1;
          if (cnt_q == FP_LAST) state_d = S_WB;
        end
        S_WB: begin
          pc_write = 1'b1;
          state_d  = S_IDLE;
          if (is_r) begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
          end else if (is_imm) begin
            reg_write = 1'b1;
          end else if (is_lw) begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
          end else if (is_lwc1 || is_fpop) begin
            fp_reg_write = 1'b1;
          end else if (is_mfc1) begin
            reg_write      = 1'b1;
            move_fp_to_cpu = 1'b1;
          end else if (is_mtc1) begin
            fp_reg_write   = 1'b1;
            move_cpu_to_fp = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign dbg_o = rst ? 20'd0 : {state_q, op_q, fmt_q, funct_q};

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. A per-cycle model of the expected strobes feeds a queue,
// and each queue entry is compared with the DUT outputs on the following falling edge.
module tb_multicycle_control_fsm;
  localparam int FP_LAT = 4;
  localparam int MEM_TO = 16;
  localparam int W      = 23;

  localparam logic [W-1:0] B_RDY  = W'(1) << 22;
  localparam logic [W-1:0] B_IRW  = W'(1) << 21;
  localparam logic [W-1:0] B_PCW  = W'(1) << 20;
  localparam logic [W-1:0] B_RDST = W'(1) << 19;
  localparam logic [W-1:0] B_ASRC = W'(1) << 18;
  localparam logic [W-1:0] B_M2R  = W'(1) << 17;
  localparam logic [W-1:0] B_RW   = W'(1) << 16;
  localparam logic [W-1:0] B_MR   = W'(1) << 15;
  localparam logic [W-1:0] B_MW   = W'(1) << 14;
  localparam logic [W-1:0] B_BR   = W'(1) << 13;
  localparam logic [W-1:0] B_BNE  = W'(1) << 12;
  localparam logic [W-1:0] B_J    = W'(1) << 11;
  localparam logic [W-1:0] B_FPW  = W'(1) << 6;
  localparam logic [W-1:0] B_FPR  = W'(1) << 5;
  localparam logic [W-1:0] B_FPO  = W'(1) << 4;
  localparam logic [W-1:0] B_MF2C = W'(1) << 3;
  localparam logic [W-1:0] B_MC2F = W'(1) << 2;
  localparam logic [W-1:0] B_ILL  = W'(1) << 1;
  localparam logic [W-1:0] B_MERR = W'(1) << 0;

  logic clk = 1'b0;
  logic rst, instr_valid, instr_ready, mem_ready;
  logic [5:0] opcode, funct;
  logic [4:0] fmt;
  logic ir_write, pc_write, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic branch, branch_ne, jump;
  logic [1:0] alu_op, imm_op;
  logic fp_reg_write, fp_reg_read, fp_operation, move_fp_to_cpu, move_cpu_to_fp, illegal_op, mem_error;
  logic [19:0] dbg_o;
  logic [W-1:0] obs;

  logic [W-1:0] exp_q[$];
  bit           mr_q[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.FP_LATENCY(FP_LAT), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .fmt(fmt), .funct(funct), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .branch_ne(branch_ne), .jump(jump), .alu_op(alu_op), .imm_op(imm_op),
    .fp_reg_write(fp_reg_write), .fp_reg_read(fp_reg_read), .fp_operation(fp_operation),
    .move_fp_to_cpu(move_fp_to_cpu), .move_cpu_to_fp(move_cpu_to_fp),
    .illegal_op(illegal_op), .mem_error(mem_error), .dbg_o(dbg_o)
  );

  assign obs = {instr_ready, ir_write, pc_write, reg_dst, alu_src, mem_to_reg, reg_write,
                mem_read, mem_write, branch, branch_ne, jump, alu_op, imm_op,
                fp_reg_write, fp_reg_read, fp_operation, move_fp_to_cpu, move_cpu_to_fp,
                illegal_op, mem_error};

  function automatic logic [W-1:0] aluv(input logic [1:0] a);
    return W'(a) << 9;
  endfunction

  function automatic logic [W-1:0] immv(input logic [1:0] i);
    return W'(i) << 7;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input logic [W-1:0] v, input bit m);
    exp_q.push_back(v);
    mr_q.push_back(m);
  endtask

  // Expected strobes per cycle from acceptance up to the next ready cycle.
  // rdy_at is the S_MEM cycle (1-based) on which mem_ready is driven; 0 means never.
  task automatic build(input logic [5:0] op, input logic [4:0] fm, input int rdy_at);
    bit ld, st, swc1, imm, br, jmp, r, cp1, mv;
    logic [W-1:0] ex, wb, v;
    ld = 0; st = 0; swc1 = 0; imm = 0; br = 0; jmp = 0; r = 0; cp1 = 0; mv = 0;
    ex = '0; wb = B_PCW;
    case (op)
      6'b000000: begin r = 1; ex = aluv(2'b10); wb |= B_RDST | B_RW; end
      6'b100011: begin ld = 1; ex = B_ASRC; wb |= B_M2R | B_RW; end
      6'b110001: begin ld = 1; ex = B_ASRC; wb |= B_FPW; end
      6'b101011: begin st = 1; ex = B_ASRC; end
      6'b111001: begin st = 1; swc1 = 1; ex = B_ASRC; end
      6'b000100: begin br = 1; ex = aluv(2'b01) | B_BR | B_PCW; end
      6'b000101: begin br = 1; ex = aluv(2'b01) | B_BR | B_BNE | B_PCW; end
      6'b000010: begin jmp = 1; ex = B_J | B_PCW; end
      6'b001000: begin imm = 1; ex = B_ASRC; wb |= B_RW; end
      6'b001100: begin imm = 1; ex = B_ASRC | aluv(2'b11) | immv(2'b00); wb |= B_RW; end
      6'b001101: begin imm = 1; ex = B_ASRC | aluv(2'b11) | immv(2'b01); wb |= B_RW; end
      6'b001110: begin imm = 1; ex = B_ASRC | aluv(2'b11) | immv(2'b10); wb |= B_RW; end
      6'b001111: begin imm = 1; ex = B_ASRC | aluv(2'b11) | immv(2'b11); wb |= B_RW; end
      6'b010001: begin
        cp1 = 1;
        if (fm == 5'b00000)      begin mv = 1; wb |= B_RW | B_MF2C; end
        else if (fm == 5'b00100) begin mv = 1; wb |= B_FPW | B_MC2F; end
        else                     wb |= B_FPW;
      end
      default: ;
    endcase
    push(B_RDY | B_IRW, 1'($urandom_range(0, 1)));
    if (!(r || ld || st || br || jmp || imm || cp1)) begin
      push(B_ILL | B_PCW, 1'($urandom_range(0, 1)));
      push(B_RDY, 1'($urandom_range(0, 1)));
      return;
    end
    push('0, 1'($urandom_range(0, 1)));
    if (cp1) begin
      if (!mv) for (int k = 0; k < FP_LAT; k++) push(B_FPO | B_FPR, 1'($urandom_range(0, 1)));
    end else begin
      push(ex, 1'($urandom_range(0, 1)));
      if (br || jmp) begin
        push(B_RDY, 1'($urandom_range(0, 1)));
        return;
      end
      if (ld || st) begin
        for (int k = 1; k <= MEM_TO; k++) begin
          v = ld ? B_MR : (B_MW | (swc1 ? B_FPR : '0));
          if (k == rdy_at) begin
            push(st ? (v | B_PCW) : v, 1'b1);
            break;
          end else if (k == MEM_TO) begin
            push(v | B_MERR, 1'b0);
            push(B_RDY, 1'($urandom_range(0, 1)));
            return;
          end else push(v, 1'b0);
        end
        if (st) begin
          push(B_RDY, 1'($urandom_range(0, 1)));
          return;
        end
      end
    end
    push(wb, 1'($urandom_range(0, 1)));
    push(B_RDY, 1'($urandom_range(0, 1)));
  endtask

  // Drives one instruction and checks every cycle. abort_at >= 0 asserts rst on that cycle instead.
  task automatic run(input string name, input logic [5:0] op, input logic [4:0] fm,
                     input logic [5:0] fn, input int rdy_at, input int abort_at);
    logic [W-1:0] e;
    int idx;
    build(op, fm, rdy_at);
    idx = 0;
    while (exp_q.size() > 0) begin
      if (idx == abort_at) begin
        exp_q.delete();
        mr_q.delete();
        rst = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check($sformatf("%s_rst%0d", name, k), obs, '0);
          @(posedge clk); #1;
        end
        rst = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
        break;
      end
      e = exp_q.pop_front();
      mem_ready = mr_q.pop_front();
      if (idx == 0) begin
        instr_valid = 1'b1; opcode = op; fmt = fm; funct = fn;
      end else begin
        instr_valid = (exp_q.size() == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        opcode = 6'($urandom); fmt = 5'($urandom); funct = 6'($urandom);
      end
      @(negedge clk);
      check($sformatf("%s_c%0d", name, idx), obs, e);
      if (idx == 1) check($sformatf("%s_fields", name), {6'b0, dbg_o[16:0]}, {6'b0, op, fm, fn});
      @(posedge clk); #1;
      idx++;
    end
    instr_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1;
    opcode = 6'b000000; fmt = 5'b0; funct = 6'b100000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", obs, '0);
    check("reset_dbg", {3'b0, dbg_o}, '0);
    @(posedge clk); #1;
    rst = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check("idle_ready", obs, B_RDY);
    @(posedge clk); #1;

    run("add",      6'b000000, 5'b00000, 6'b100000, 0, -1);
    run("lw",       6'b100011, 5'b01010, 6'b000001, 3, -1);
    run("sw_tmo",   6'b101011, 5'b00011, 6'b000010, 0, -1);
    run("sw_last",  6'b101011, 5'b00011, 6'b000011, MEM_TO, -1);
    run("lwc1",     6'b110001, 5'b00111, 6'b000100, 1, -1);
    run("swc1",     6'b111001, 5'b01111, 6'b000101, 2, -1);
    run("lw_tmo",   6'b100011, 5'b00001, 6'b000110, 0, -1);
    run("addi",     6'b001000, 5'b10001, 6'b111111, 0, -1);
    run("andi",     6'b001100, 5'b00010, 6'b010101, 0, -1);
    run("ori",      6'b001101, 5'b00010, 6'b101010, 0, -1);
    run("xori",     6'b001110, 5'b00010, 6'b110011, 0, -1);
    run("lui",      6'b001111, 5'b00010, 6'b001100, 0, -1);
    run("beq",      6'b000100, 5'b00000, 6'b000000, 0, -1);
    run("bne",      6'b000101, 5'b00000, 6'b000000, 0, -1);
    run("j",        6'b000010, 5'b00000, 6'b000000, 0, -1);
    run("mfc1",     6'b010001, 5'b00000, 6'b000000, 0, -1);
    run("mtc1",     6'b010001, 5'b00100, 6'b000000, 0, -1);
    run("fp_op",    6'b010001, 5'b10000, 6'b000010, 0, -1);
    run("fp_fmt1",  6'b010001, 5'b00001, 6'b000000, 0, -1);
    run("illegal",  6'b111111, 5'b00000, 6'b000000, 0, -1);
    run("add_b2b",  6'b000000, 5'b00000, 6'b100010, 0, -1);
    run("fp_abort", 6'b010001, 5'b10000, 6'b000000, 0, 3);
    run("ori_post", 6'b001101, 5'b00000, 6'b000000, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
